// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, iteration count and magnitude helper for the divider
package div_pkg;

    localparam int DIV_W    = 32;
    localparam int DIV_ITER = DIV_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ZERO = 2'b01,
        ON   = 2'b10,
        END  = 2'b11
    } state_t;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DIV_W-1:0] abs_w(input logic [DIV_W-1:0] x);
        return x[DIV_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a dividend bit, trial-subtract the divisor)
module div_step
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_W
) (
    input  logic [DATA_W:0]   rem,
    input  logic              din,
    input  logic [DATA_W-1:0] dvs,
    output logic [DATA_W:0]   rem_next,
    output logic              q
);

    logic [DATA_W+1:0] sh;
    logic [DATA_W+1:0] diff;

    assign sh       = {rem, din};
    assign diff     = sh - {2'b00, dvs};
    assign q        = ~diff[DATA_W+1];
    assign rem_next = q ? diff[DATA_W:0] : sh[DATA_W:0];

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative MIPS DIV/DIVU unit producing {remainder, quotient} for HI/LO
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_W,
    parameter int ITER   = DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    input  logic                annul,
    output logic                busy,
    output logic                ready,
    output logic                div_by_zero,
    output logic [2*DATA_W-1:0] result
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [DATA_W:0]   rem;
    logic [DATA_W:0]   step_rem;
    logic              step_q;
    logic [DATA_W-1:0] dq;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] raw_a;
    logic              neg_a;
    logic              neg_b;
    logic              dz;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;
    logic              accept;

    assign accept = start && !annul;
    assign busy   = state != IDLE;

    // dq starts as the dividend magnitude and is shifted left each step,
    // so its MSB feeds the step and the quotient bits fill in from the LSB
    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem),
        .din      (dq[DATA_W-1]),
        .dvs      (dvs),
        .rem_next (step_rem),
        .q        (step_q)
    );

    assign q_fix = (neg_a ^ neg_b) ? -dq : dq;
    assign r_fix = neg_a ? -rem[DATA_W-1:0] : rem[DATA_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; annul drops any in-flight work except an already committed END
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? ((opb == '0) ? ZERO : ON) : IDLE;
            ZERO:    state_next = annul ? IDLE : END;
            ON:      state_next = annul ? IDLE : ((cnt == LAST) ? END : ON);
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered result/ready
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            dq          <= '0;
            dvs         <= '0;
            raw_a       <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            dz          <= 1'b0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else begin
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    raw_a <= opa;
                    dq    <= signed_div ? abs_w(opa) : opa;
                    dvs   <= signed_div ? abs_w(opb) : opb;
                    neg_a <= signed_div && opa[DATA_W-1];
                    neg_b <= signed_div && opb[DATA_W-1];
                    dz    <= opb == '0;
                    rem   <= '0;
                    cnt   <= '0;
                end
                ON: begin
                    rem <= step_rem;
                    dq  <= {dq[DATA_W-2:0], step_q};
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                END: begin
                    result      <= dz ? {raw_a, {DATA_W{1'b1}}} : {r_fix, q_fix};
                    ready       <= 1'b1;
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard-driven bench for the iterative divider
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        busy;
    logic        ready;
    logic        div_by_zero;
    logic [63:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .opa         (opa),
        .opb         (opb),
        .annul       (annul),
        .busy        (busy),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (!s) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit track);
        opa = a;
        opb = b;
        signed_div = s;
        start = 1'b1;
        if (track) exp_q.push_back({b == 32'h0, model(a, b, s)});
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!ready && lat < 60) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy, ready, div_by_zero, result} !== 67'h0) begin
            n_bad++;
            $display("FAIL reset: got busy=%b ready=%b dbz=%b result=%h want all zero", busy, ready, div_by_zero, result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int lat, bc;
        logic [64:0] e;
        issue(32'd100, 32'd7, 1'b0, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL unsigned_latency: got %0d want 33", lat); end
        n_cmp++;
        if (bc !== 33) begin n_bad++; $display("FAIL unsigned_busy: got %0d want 33", bc); end
        n_cmp++;
        if (result !== 64'h00000002_0000000E || result !== e[63:0]) begin
            n_bad++;
            $display("FAIL unsigned_result: got %h want %h", result, e[63:0]);
        end
        tick();
        n_cmp++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_pulse: got ready=%b busy=%b want 0 0", ready, busy);
        end
    endtask

    task automatic test_signed();
        int lat, bc;
        logic [64:0] e;
        issue(32'hFFFFFFF9, 32'h2, 1'b1, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== 64'hFFFFFFFF_FFFFFFFD || result !== e[63:0]) begin
            n_bad++;
            $display("FAIL signed_neg_dividend: got %h want %h", result, e[63:0]);
        end
        tick();
        issue(32'h7, 32'hFFFFFFFE, 1'b1, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== 64'h00000001_FFFFFFFD || result !== e[63:0]) begin
            n_bad++;
            $display("FAIL signed_neg_divisor: got %h want %h", result, e[63:0]);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int lat, bc;
        logic [64:0] e;
        issue(32'd5, 32'd0, 1'b1, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL dz_latency: got %0d want 2", lat); end
        n_cmp++;
        if ({div_by_zero, result} !== {1'b1, 64'h00000005_FFFFFFFF} || {div_by_zero, result} !== e) begin
            n_bad++;
            $display("FAIL dz_result: got dbz=%b %h want %b %h", div_by_zero, result, e[64], e[63:0]);
        end
        tick();
        n_cmp++;
        if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dz_clear: got %b want 0", div_by_zero); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        logic [64:0] e;
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== 33 || result !== 64'h00000000_80000000 || result !== e[63:0]) begin
            n_bad++;
            $display("FAIL signed_overflow: got lat=%0d %h want 33 %h", lat, result, e[63:0]);
        end
        tick();
        issue(32'hFFFFFFFF, 32'h1, 1'b0, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== 64'h00000000_FFFFFFFF || result !== e[63:0]) begin
            n_bad++;
            $display("FAIL unsigned_max: got %h want %h", result, e[63:0]);
        end
        tick();
    endtask

    task automatic test_annul();
        int lat, bc, seen;
        logic [63:0] prior;
        logic [64:0] e;
        prior = result;
        issue(32'd1000, 32'd3, 1'b0, 0);
        repeat (9) tick();
        annul = 1'b1;
        tick();
        annul = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL annul_busy: got %b want 0", busy); end
        opa = 32'd20;
        opb = 32'd4;
        start = 1'b1;
        annul = 1'b1;
        tick();
        start = 1'b0;
        annul = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL annul_start_idle: got busy=%b want 0", busy); end
        seen = 0;
        repeat (40) begin
            if (ready) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0 || result !== prior) begin
            n_bad++;
            $display("FAIL annul_no_ready: got %0d pulses result %h want 0 pulses %h", seen, result, prior);
        end
        issue(32'd9, 32'd3, 1'b0, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== 33 || result !== 64'h00000000_00000003 || result !== e[63:0]) begin
            n_bad++;
            $display("FAIL after_annul: got lat=%0d %h want 33 %h", lat, result, e[63:0]);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        int seen;
        issue(32'd12345, 32'd67, 1'b0, 0);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, ready, div_by_zero, result} !== 67'h0) begin
            n_bad++;
            $display("FAIL rst_mid: got busy=%b ready=%b dbz=%b result=%h want all zero", busy, ready, div_by_zero, result);
        end
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            if (ready) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL rst_no_ready: got %0d pulses want 0", seen); end
    endtask

    task automatic test_busy_start();
        int seen;
        logic [63:0] got;
        logic [64:0] e;
        issue(32'd50, 32'd5, 1'b0, 1);
        repeat (5) tick();
        opa = 32'd77;
        opb = 32'd2;
        signed_div = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        got = '0;
        repeat (45) begin
            if (ready) begin seen++; got = result; end
            tick();
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (seen !== 1 || got !== e[63:0]) begin
            n_bad++;
            $display("FAIL busy_start_ignored: got %0d pulses %h want 1 pulse %h", seen, got, e[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [64:0] e;
        issue(32'd1000000, 32'd999, 1'b0, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== e[63:0]) begin n_bad++; $display("FAIL b2b_first: got %h want %h", result, e[63:0]); end
        issue(32'hFFFF0000, 32'd12, 1'b1, 1);
        wait_ready(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== 33 || result !== e[63:0]) begin
            n_bad++;
            $display("FAIL b2b_second: got lat=%0d %h want 33 %h", lat, result, e[63:0]);
        end
        tick();
    endtask

    task automatic test_random();
        int lat, bc;
        logic [31:0] a, b;
        logic s;
        logic [64:0] e;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = (i % 4 == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            s = 1'($urandom_range(0, 1));
            issue(a, b, s, 1);
            wait_ready(lat, bc);
            e = exp_q.pop_front();
            n_cmp++;
            if ({div_by_zero, result} !== e) begin
                n_bad++;
                $display("FAIL random_%0d: a=%h b=%h s=%b got %b %h want %b %h", i, a, b, s, div_by_zero, result, e[64], e[63:0]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_annul();
        test_rst_mid();
        test_busy_start();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
